maxpool2d_2x2_stride2: RTL and testbench

//  Streaming 2x2 max-pooling, stride 2, on IEEE-754 single-precision pixels.

---
 rtl/maxpool2d_2x2_stride2_if.sv | 28 ++
 rtl/maxpool2d_2x2_stride2.sv | 119 +++++++++++
 tb/tb_maxpool2d_2x2_stride2.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2d_2x2_stride2_if.sv
// rtl/maxpool2d_2x2_stride2_if.sv - pixel stream in/out bundle for the 2x2 max-pool block
interface maxpool2d_2x2_stride2_if #(
    parameter int DATA_WIDHT = 32
);
    logic [DATA_WIDHT-1:0] Data_In;
    logic                  Valid_In;
    logic [DATA_WIDHT-1:0] Data_Out;
    logic                  Valid_Out;
    logic                  Frame_Done;

    // Pooling block side: consumes the raster stream, produces pooled pixels
    modport slave (
        input  Data_In,
        input  Valid_In,
        output Data_Out,
        output Valid_Out,
        output Frame_Done
    );

    // Upstream/downstream side: drives the raster stream, observes pooled pixels
    modport master (
        output Data_In,
        output Valid_In,
        input  Data_Out,
        input  Valid_Out,
        input  Frame_Done
    );
endinterface

// File: rtl/maxpool2d_2x2_stride2.sv
// rtl/maxpool2d_2x2_stride2.sv - streaming 2x2 stride-2 max-pool on IEEE-754 single pixels
module maxpool2d_2x2_stride2 #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 218,
    parameter int IMG_HEIGHT = 218
) (
    input  logic                           clk,
    input  logic                           rst,
    maxpool2d_2x2_stride2_if.slave         pix
);

    localparam int HALF_W   = IMG_WIDTH / 2;
    localparam int HALF_H   = IMG_HEIGHT / 2;
    localparam int CW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    // A single-entry buffer is padded to two so the index is never zero-width
    localparam int LBW      = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int LB_DEPTH = (HALF_W > 1) ? HALF_W : 2;
    localparam bit ODD_W    = (IMG_WIDTH  % 2) != 0;
    localparam bit ODD_H    = (IMG_HEIGHT % 2) != 0;

    localparam logic [CW-1:0] LAST_COL      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] LAST_PAIR_COL = CW'(2 * HALF_W - 1);
    localparam logic [RW-1:0] LAST_PAIR_ROW = RW'(2 * HALF_H - 1);

    // Map a float onto an unsigned key whose integer order equals float order (-0 < +0)
    function automatic logic [DATA_WIDHT-1:0] pool_key(input logic [DATA_WIDHT-1:0] x);
        return x[DATA_WIDHT-1] ? ~x : (x ^ {1'b1, {(DATA_WIDHT-1){1'b0}}});
    endfunction

    // Later pixel wins only when strictly larger, so ties keep the earlier pixel
    function automatic logic [DATA_WIDHT-1:0] pool_max(input logic [DATA_WIDHT-1:0] earlier,
                                                       input logic [DATA_WIDHT-1:0] later);
        return (pool_key(later) > pool_key(earlier)) ? later : earlier;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDHT-1:0] pair_q, pair_d;
    logic [DATA_WIDHT-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDHT-1:0] linebuf_q [LB_DEPTH];
    logic                  lb_we;
    logic [LBW-1:0]        lb_idx;
    logic [DATA_WIDHT-1:0] pair_max;

    assign lb_idx   = LBW'(col_q >> 1);
    assign pair_max = pool_max(pair_q, pix.Data_In);

    // Raster counters, horizontal pairing, line-buffer write and output selection
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (pix.Valid_In) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                // Trailing column of an odd-width row has no partner
                if (!(ODD_W && col_q == LAST_COL)) begin
                    pair_d = pix.Data_In;
                end
            end else if (!row_q[0]) begin
                // Trailing row of an odd-height frame has no partner
                if (!(ODD_H && row_q == LAST_ROW)) begin
                    lb_we = 1'b1;
                end
            end else begin
                data_out_d   = pool_max(linebuf_q[lb_idx], pair_max);
                valid_out_d  = 1'b1;
                frame_done_d = (col_q == LAST_PAIR_COL) && (row_q == LAST_PAIR_ROW);
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Half-width line buffer of even-row pair maxima; contents survive reset
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    assign pix.Data_Out   = data_out_q;
    assign pix.Valid_Out  = valid_out_q;
    assign pix.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_maxpool2d_2x2_stride2.sv
// tb/tb_maxpool2d_2x2_stride2.sv - directed vector bench for maxpool2d_2x2_stride2
module tb_maxpool2d_2x2_stride2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        vin = 1'b0;
    int          sel = 0;

    always #5 clk = ~clk;

    maxpool2d_2x2_stride2_if if_a ();
    maxpool2d_2x2_stride2_if if_b ();
    maxpool2d_2x2_stride2_if if_c ();

    assign if_a.Data_In  = din;
    assign if_b.Data_In  = din;
    assign if_c.Data_In  = din;
    assign if_a.Valid_In = vin && (sel == 0);
    assign if_b.Valid_In = vin && (sel == 1);
    assign if_c.Valid_In = vin && (sel == 2);

    maxpool2d_2x2_stride2 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (.clk(clk), .rst(rst), .pix(if_a));
    maxpool2d_2x2_stride2 #(.IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_b (.clk(clk), .rst(rst), .pix(if_b));
    maxpool2d_2x2_stride2 #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_c (.clk(clk), .rst(rst), .pix(if_c));

    logic [31:0] o_data;
    logic        o_valid;
    logic        o_done;

    always_comb begin
        o_data  = if_a.Data_Out;
        o_valid = if_a.Valid_Out;
        o_done  = if_a.Frame_Done;
        if (sel == 1) begin
            o_data  = if_b.Data_Out;
            o_valid = if_b.Valid_Out;
            o_done  = if_b.Frame_Done;
        end else if (sel == 2) begin
            o_data  = if_c.Data_Out;
            o_valid = if_c.Valid_Out;
            o_done  = if_c.Frame_Done;
        end
    end

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        ev;
        logic [31:0] ed;
        logic        efd;
    } vec_t;

    vec_t        vecs[$];
    int          errors  = 0;
    int          checks  = 0;
    int          fd_seen = 0;
    logic [31:0] fl   [26];
    logic [31:0] exp1 [4];
    logic [31:0] exp5 [4];

    task automatic check32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] d, input logic ev,
                        input logic [31:0] ed, input logic efd);
        vec_t t;
        t.vin = v; t.din = d; t.ev = ev; t.ed = ed; t.efd = efd;
        vecs.push_back(t);
    endtask

    task automatic run(input int s, input string name);
        sel = s;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            vin = vecs[i].vin;
            din = vecs[i].din;
            @(posedge clk);
            #1;
            check32({name, ".valid"}, i, {31'd0, o_valid}, {31'd0, vecs[i].ev});
            if (vecs[i].ev) check32({name, ".data"}, i, o_data, vecs[i].ed);
            check32({name, ".done"}, i, {31'd0, o_done}, {31'd0, vecs[i].efd});
            if (o_done) fd_seen++;
        end
        vecs.delete();
    endtask

    task automatic idle();
        @(negedge clk);
        vin = 1'b0;
        din = '0;
    endtask

    // 4x4 ramp 1..16 with optional random idle gaps before each pixel
    task automatic add_frame4(input int first, input int count, input bit gaps);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            bit odd;
            odd = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
            if (i >= first && i < first + count) begin
                if (gaps) repeat ($urandom_range(0, 2)) push(1'b0, 32'hDEADBEEF, 1'b0, '0, 1'b0);
                push(1'b1, fl[i + 1], odd, odd ? exp1[k] : '0, odd && (k == 3));
            end
            if (odd) k++;
        end
    endtask

    task automatic add_frame2(input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3, input logic [31:0] e);
        push(1'b1, p0, 1'b0, '0, 1'b0);
        push(1'b1, p1, 1'b0, '0, 1'b0);
        push(1'b1, p2, 1'b0, '0, 1'b0);
        push(1'b1, p3, 1'b1, e,  1'b1);
    endtask

    initial begin
        fl = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000,
               32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000, 32'h41600000,
               32'h41700000, 32'h41800000, 32'h41880000, 32'h41900000, 32'h41980000,
               32'h41A00000, 32'h41A80000, 32'h41B00000, 32'h41B80000, 32'h41C00000,
               32'h41C80000};
        exp1 = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        exp5 = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};

        // Reset state of every instance
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check32("rst.data",  s, o_data, 32'h0);
            check32("rst.valid", s, {31'd0, o_valid}, 32'h0);
            check32("rst.done",  s, {31'd0, o_done}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 4x4 ramp, Valid_In held high
        add_frame4(0, 16, 1'b0);
        run(0, "t1");
        idle();

        // 2x2 frames: negatives, signed zeros, mixed signs/infinities, buffer wins
        add_frame2(32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000, 32'hBF000000);
        add_frame2(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
        add_frame2(32'h3F800000, 32'hBF800000, 32'h7F800000, 32'hFF800000, 32'h7F800000);
        add_frame2(32'h40000000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000);
        run(1, "t2");
        idle();

        // 4x4 ramp with random gaps
        add_frame4(0, 16, 1'b1);
        run(0, "t4");
        idle();

        // 5x5 ramp: trailing column and row dropped
        begin
            int k;
            k = 0;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    bit o;
                    o = (r == 1 || r == 3) && (c == 1 || c == 3);
                    push(1'b1, fl[r * 5 + c + 1], o, o ? exp5[k] : '0, o && (k == 3));
                    if (o) k++;
                end
            end
        end
        run(2, "t5");
        idle();

        // Asynchronous reset in the middle of row 1, then two back-to-back frames
        add_frame4(0, 6, 1'b0);
        run(0, "t6pre");
        #2 rst = 1'b1;
        #1;
        check32("t6.async_data",  0, o_data, 32'h0);
        check32("t6.async_valid", 0, {31'd0, o_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vin = 1'b1;
            din = fl[7];
            @(posedge clk);
            #1;
            check32("t6.hold_data",  i, o_data, 32'h0);
            check32("t6.hold_valid", i, {31'd0, o_valid}, 32'h0);
            check32("t6.hold_done",  i, {31'd0, o_done}, 32'h0);
        end
        @(negedge clk);
        vin = 1'b0;
        rst = 1'b0;
        fd_seen = 0;
        add_frame4(0, 16, 1'b0);
        add_frame4(0, 16, 1'b0);
        run(0, "t6");
        check32("t6.frame_done_count", 0, fd_seen, 2);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
